// File: rtl/vga_scan_gen.sv
// -----------------------------------------------------------------------------
// vga_scan_gen
//   VGA raster generator and framebuffer scanner.
//   A pixel tick (pix_ce) is derived from clock_50 by a toggling phase bit. The
//   h/v counters walk the full raster. Framebuffer addresses are generated for
//   a scaled window inside the visible area. The timing flags are delayed so
//   they line up with pixel data that returns RD_LAT ticks after its address.
//   The area outside the window but inside the visible area shows border_rgb.
//
// Ports
//   clock_50      system clock (pixel clock is clock_50/2)
//   reset         synchronous, active-low
//   d             framebuffer read data, valid RD_LAT pixel ticks after adr
//   border_rgb    colour for visible pixels outside the window
//   adr           framebuffer read address
//   vga_clk       pixel clock to the DAC
//   vga_r/g/b     pixel channels, PIX_W/3 bits each
//   vga_blank_n   low outside the visible area
//   vga_sync_n    tied low (no sync-on-green)
//   vga_hs/vga_vs sync outputs with HS_POL/VS_POL active level
//   frame_start   one clock_50 pulse per frame
// -----------------------------------------------------------------------------
module vga_scan_gen #(
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int WIN_X0  = 40,
    parameter int WIN_W   = 560,
    parameter int WIN_Y0  = 48,
    parameter int WIN_H   = 384,
    parameter int SCALE_X = 2,
    parameter int SCALE_Y = 2,
    parameter int ADR_W   = 16,
    parameter int PIX_W   = 24,
    parameter int RD_LAT  = 2,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0
) (
    input  logic               clock_50,
    input  logic               reset,
    input  logic [PIX_W-1:0]   d,
    input  logic [PIX_W-1:0]   border_rgb,
    output logic [ADR_W-1:0]   adr,
    output logic               vga_clk,
    output logic [PIX_W/3-1:0] vga_r,
    output logic [PIX_W/3-1:0] vga_g,
    output logic [PIX_W/3-1:0] vga_b,
    output logic               vga_blank_n,
    output logic               vga_sync_n,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               frame_start
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int CW    = PIX_W / 3;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] WX_FIRST = HW'(WIN_X0);
    localparam logic [HW-1:0] WX_LAST  = HW'(WIN_X0 + WIN_W - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] WY_FIRST = VW'(WIN_Y0);
    localparam logic [VW-1:0] WY_LAST  = VW'(WIN_Y0 + WIN_H - 1);
    localparam logic [1:0]    SX_LAST  = 2'(SCALE_X - 1);
    localparam logic [1:0]    SY_LAST  = 2'(SCALE_Y - 1);

    logic             ph_q;
    logic [HW-1:0]    h_q, h_d;
    logic [VW-1:0]    v_q, v_d;
    logic [1:0]       sx_q, sx_d;
    logic [1:0]       sy_q, sy_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [ADR_W-1:0] line_base_q, line_base_d;
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic             blank_n_q;
    logic             hs_q;
    logic             vs_q;
    logic             frame_start_q;

    logic             pix_ce;
    logic             vis_now, win_now, hs_now, vs_now;
    logic             frame_end;
    logic [3:0]       flags_now;   // {vis, win, hs, vs} for the current counter state
    logic [3:0]       flags_tap;   // same flags, RD_LAT ticks old

    // Pixel tick falls on every second clock_50 cycle, when vga_clk is high.
    assign pix_ce = ph_q;

    assign vis_now   = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    assign win_now   = (h_q >= WX_FIRST) && (h_q <= WX_LAST) &&
                       (v_q >= WY_FIRST) && (v_q <= WY_LAST);
    assign hs_now    = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    assign vs_now    = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    assign frame_end = (h_q == H_LAST) && (v_q == V_LAST);
    assign flags_now = {vis_now, win_now, hs_now, vs_now};

    // Counter and address next state. The address points at the pixel held
    // in the counters; it steps after the last replica of each source pixel
    // and rewinds to line_base until the last replica of a source line.
    always_comb begin
        h_d         = h_q + HW'(1);
        v_d         = v_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        adr_d       = adr_q;
        line_base_d = line_base_q;

        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end

        if (win_now) begin
            if (sx_q == SX_LAST) begin
                sx_d  = '0;
                adr_d = adr_q + ADR_W'(1);
            end else begin
                sx_d = sx_q + 2'd1;
            end
            // WIN_W is a multiple of SCALE_X, so sx is at SX_LAST here.
            if (h_q == WX_LAST) begin
                if (sy_q == SY_LAST) begin
                    sy_d        = '0;
                    line_base_d = adr_q + ADR_W'(1);
                end else begin
                    sy_d  = sy_q + 2'd1;
                    adr_d = line_base_q;
                end
            end
        end

        if (frame_end) begin
            adr_d       = '0;
            line_base_d = '0;
            sx_d        = '0;
            sy_d        = '0;
        end
    end

    // Delay line for the timing flags: RD_LAT registered stages, the output
    // register below supplies the final tick so data and flags meet there.
    generate
        if (RD_LAT == 0) begin : g_no_lat
            assign flags_tap = flags_now;
        end else begin : g_lat
            for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
                logic [3:0] stage_q;
                logic [3:0] stage_in;
                if (gi == 0) begin : g_first
                    assign stage_in = flags_now;
                end else begin : g_rest
                    assign stage_in = g_stage[gi-1].stage_q;
                end
                always_ff @(posedge clock_50) begin
                    if (!reset) begin
                        stage_q <= '0;
                    end else if (pix_ce) begin
                        stage_q <= stage_in;
                    end
                end
            end
            assign flags_tap = g_stage[RD_LAT-1].stage_q;
        end
    endgenerate

    always_comb begin
        rgb_d = '0;
        if (flags_tap[2]) begin
            rgb_d = d;
        end else if (flags_tap[3]) begin
            rgb_d = border_rgb;
        end
    end

    always_ff @(posedge clock_50) begin
        if (!reset) begin
            ph_q          <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            adr_q         <= '0;
            line_base_q   <= '0;
            rgb_q         <= '0;
            blank_n_q     <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            frame_start_q <= 1'b0;
        end else begin
            ph_q          <= ~ph_q;
            // Pulse on the tick taken while the counters sit at (0,0).
            frame_start_q <= pix_ce && (h_q == '0) && (v_q == '0);
            if (pix_ce) begin
                h_q         <= h_d;
                v_q         <= v_d;
                sx_q        <= sx_d;
                sy_q        <= sy_d;
                adr_q       <= adr_d;
                line_base_q <= line_base_d;
                rgb_q       <= rgb_d;
                blank_n_q   <= flags_tap[3];
                hs_q        <= flags_tap[1] ? HS_POL : ~HS_POL;
                vs_q        <= flags_tap[0] ? VS_POL : ~VS_POL;
            end
        end
    end

    assign adr         = adr_q;
    assign vga_clk     = ph_q;
    assign vga_r       = rgb_q[PIX_W-1 -: CW];
    assign vga_g       = rgb_q[2*CW-1 -: CW];
    assign vga_b       = rgb_q[CW-1:0];
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_gen
//   Bench for vga_scan_gen on a shrunken raster (56 x 27) so several whole
//   frames fit in a short run. A framebuffer with random contents answers
//   reads RD_LAT pixel ticks after the address. Expected outputs are derived
//   from the pixel index: pixel k sits at (k mod H_TOT, (k / H_TOT) mod V_TOT)
//   and its outputs show up RD_LAT+1 ticks after its counter state.
// -----------------------------------------------------------------------------
module tb_vga_scan_gen;
    localparam int H_VIS   = 40;
    localparam int H_FP    = 4;
    localparam int H_SYNC  = 6;
    localparam int H_BP    = 6;
    localparam int V_VIS   = 20;
    localparam int V_FP    = 2;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 3;
    localparam int WIN_X0  = 6;
    localparam int WIN_W   = 24;
    localparam int WIN_Y0  = 4;
    localparam int WIN_H   = 12;
    localparam int SCALE_X = 2;
    localparam int SCALE_Y = 3;
    localparam int ADR_W   = 16;
    localparam int PIX_W   = 24;
    localparam int RD_LAT  = 2;
    localparam bit HS_POL  = 1'b0;
    localparam bit VS_POL  = 1'b0;
    localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOT * V_TOT;

    logic             clock_50 = 1'b0;
    logic             reset    = 1'b0;
    logic [PIX_W-1:0] d;
    logic [PIX_W-1:0] border_rgb = '0;
    logic [ADR_W-1:0] adr;
    logic             vga_clk;
    logic [7:0]       vga_r, vga_g, vga_b;
    logic             vga_blank_n, vga_sync_n, vga_hs, vga_vs, frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    vga_scan_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .WIN_X0(WIN_X0), .WIN_W(WIN_W), .WIN_Y0(WIN_Y0), .WIN_H(WIN_H),
        .SCALE_X(SCALE_X), .SCALE_Y(SCALE_Y), .ADR_W(ADR_W), .PIX_W(PIX_W),
        .RD_LAT(RD_LAT), .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .clock_50(clock_50), .reset(reset), .d(d), .border_rgb(border_rgb),
        .adr(adr), .vga_clk(vga_clk), .vga_r(vga_r), .vga_g(vga_g),
        .vga_b(vga_b), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
    );

    always #10 clock_50 = ~clock_50;

    // Environment: bench-side pixel phase, tick count since reset release,
    // and a framebuffer with RD_LAT ticks of read latency.
    logic             bench_ph;
    int               tick_j;
    logic [PIX_W-1:0] fb [256];
    logic [PIX_W-1:0] rd_pipe [RD_LAT];

    always @(posedge clock_50) begin
        if (!reset) begin
            bench_ph <= 1'b0;
            tick_j   <= 0;
        end else begin
            bench_ph <= ~bench_ph;
            if (bench_ph) begin
                tick_j     <= tick_j + 1;
                rd_pipe[0] <= fb[adr[7:0]];
                for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end
    assign d = rd_pipe[RD_LAT-1];

    function automatic int px_h(input int k);
        return k % H_TOT;
    endfunction

    function automatic int px_v(input int k);
        return (k / H_TOT) % V_TOT;
    endfunction

    function automatic bit in_win(input int h, input int v);
        return h >= WIN_X0 && h < WIN_X0 + WIN_W && v >= WIN_Y0 && v < WIN_Y0 + WIN_H;
    endfunction

    function automatic int win_addr(input int h, input int v);
        return ((v - WIN_Y0) / SCALE_Y) * (WIN_W / SCALE_X) + (h - WIN_X0) / SCALE_X;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (4) @(posedge clock_50);
        @(negedge clock_50);
        n_tests++; if (adr !== '0) begin n_fail++; $display("FAIL reset_adr got %h want 0", adr); end
        n_tests++; if (vga_clk !== 1'b0) begin n_fail++; $display("FAIL reset_vga_clk got %b want 0", vga_clk); end
        n_tests++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb got %h want 0", {vga_r, vga_g, vga_b}); end
        n_tests++; if (vga_blank_n !== 1'b0) begin n_fail++; $display("FAIL reset_blank_n got %b want 0", vga_blank_n); end
        n_tests++; if (vga_sync_n !== 1'b0) begin n_fail++; $display("FAIL reset_sync_n got %b want 0", vga_sync_n); end
        n_tests++; if (vga_hs !== ~HS_POL) begin n_fail++; $display("FAIL reset_hs got %b want %b", vga_hs, ~HS_POL); end
        n_tests++; if (vga_vs !== ~VS_POL) begin n_fail++; $display("FAIL reset_vs got %b want %b", vga_vs, ~VS_POL); end
        n_tests++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
        $display("[TB] reset state checked");
    endtask

    // Releases reset, expects frame_start two clocks later, one clock wide,
    // then measures the distance to the next pulse.
    task automatic test_frame_start();
        int c;
        int first_at;
        int period;
        reset = 1'b1;
        first_at = -1;
        for (c = 1; c <= 20; c++) begin
            @(negedge clock_50);
            if (frame_start === 1'b1) begin
                first_at = c;
                break;
            end
        end
        n_tests++; if (first_at != 2) begin n_fail++; $display("FAIL first_frame_start got clock %0d want 2", first_at); end
        @(negedge clock_50);
        n_tests++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL frame_start_width got %b want 0", frame_start); end
        period = -1;
        for (c = 2; c <= 4 * FRAME + 8; c++) begin
            @(negedge clock_50);
            if (frame_start === 1'b1) begin
                period = c;
                break;
            end
        end
        n_tests++; if (period != 2 * FRAME) begin n_fail++; $display("FAIL frame_period got %0d clocks want %0d", period, 2 * FRAME); end
        $display("[TB] frame_start period %0d clocks", period);
    endtask

    // Checks every output on every clock over whole frames.
    task automatic test_scan(input int nframes, input logic [PIX_W-1:0] border);
        int prev;
        int k, h, v, hc, vc;
        bit pix_edge;
        bit exp_fs;
        logic [PIX_W-1:0] exp_rgb;
        logic exp_bl, exp_hs, exp_vs;
        border_rgb = border;
        @(negedge clock_50);
        prev = tick_j;
        for (int c = 0; c < nframes * FRAME * 2; c++) begin
            @(negedge clock_50);
            pix_edge = (tick_j != prev);
            prev = tick_j;
            n_tests++; if (vga_clk !== bench_ph) begin n_fail++; $display("FAIL vga_clk got %b want %b", vga_clk, bench_ph); end
            exp_fs = pix_edge && ((tick_j - 1) % FRAME == 0);
            n_tests++; if (frame_start !== exp_fs) begin n_fail++; $display("FAIL frame_start tick %0d got %b want %b", tick_j, frame_start, exp_fs); end
            if (pix_edge) begin
                k = tick_j - (RD_LAT + 1);
                exp_rgb = '0;
                exp_bl  = 1'b0;
                exp_hs  = ~HS_POL;
                exp_vs  = ~VS_POL;
                if (k >= 0) begin
                    h = px_h(k);
                    v = px_v(k);
                    exp_bl = (h < H_VIS) && (v < V_VIS);
                    if (in_win(h, v)) exp_rgb = fb[win_addr(h, v)];
                    else if (exp_bl) exp_rgb = border;
                    if (h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC) exp_hs = HS_POL;
                    if (v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC) exp_vs = VS_POL;
                end
                n_tests++; if ({vga_r, vga_g, vga_b} !== exp_rgb) begin n_fail++; $display("FAIL rgb pixel %0d got %h want %h", k, {vga_r, vga_g, vga_b}, exp_rgb); end
                n_tests++; if (vga_blank_n !== exp_bl) begin n_fail++; $display("FAIL blank_n pixel %0d got %b want %b", k, vga_blank_n, exp_bl); end
                n_tests++; if (vga_hs !== exp_hs) begin n_fail++; $display("FAIL hs pixel %0d got %b want %b", k, vga_hs, exp_hs); end
                n_tests++; if (vga_vs !== exp_vs) begin n_fail++; $display("FAIL vs pixel %0d got %b want %b", k, vga_vs, exp_vs); end
                n_tests++; if (vga_sync_n !== 1'b0) begin n_fail++; $display("FAIL sync_n got %b want 0", vga_sync_n); end
                hc = px_h(tick_j);
                vc = px_v(tick_j);
                if (in_win(hc, vc)) begin
                    n_tests++; if (adr !== ADR_W'(win_addr(hc, vc))) begin n_fail++; $display("FAIL adr at (%0d,%0d) got %0d want %0d", hc, vc, adr, win_addr(hc, vc)); end
                end else if (vc < WIN_Y0) begin
                    n_tests++; if (adr !== '0) begin n_fail++; $display("FAIL adr_top at (%0d,%0d) got %0d want 0", hc, vc, adr); end
                end
                if (hc == H_TOT - 1) $display("[TB] scan line v=%0d checked (%0d comparisons total)", vc, n_tests);
            end
        end
    endtask

    // Over exactly one frame of ticks: sync run starts and total active ticks.
    task automatic test_sync_widths();
        int prev, hs_ticks, vs_ticks, runs;
        logic hs_prev;
        @(negedge clock_50);
        prev = tick_j;
        hs_prev = vga_hs;
        hs_ticks = 0; vs_ticks = 0; runs = 0;
        for (int c = 0; c < FRAME * 2; c++) begin
            @(negedge clock_50);
            if (tick_j != prev) begin
                prev = tick_j;
                if (vga_hs === HS_POL) hs_ticks++;
                if (vga_vs === VS_POL) vs_ticks++;
                if (vga_hs === HS_POL && hs_prev !== HS_POL) begin
                    runs++;
                    n_tests++; if (px_h(tick_j - (RD_LAT + 1)) != H_VIS + H_FP) begin n_fail++; $display("FAIL hs_start got h=%0d want %0d", px_h(tick_j - (RD_LAT + 1)), H_VIS + H_FP); end
                end
                hs_prev = vga_hs;
            end
        end
        n_tests++; if (hs_ticks != V_TOT * H_SYNC) begin n_fail++; $display("FAIL hs_ticks got %0d want %0d", hs_ticks, V_TOT * H_SYNC); end
        n_tests++; if (vs_ticks != V_SYNC * H_TOT) begin n_fail++; $display("FAIL vs_ticks got %0d want %0d", vs_ticks, V_SYNC * H_TOT); end
        n_tests++; if (runs != V_TOT) begin n_fail++; $display("FAIL hs_runs got %0d want %0d", runs, V_TOT); end
        $display("[TB] sync frame: hs %0d ticks in %0d runs, vs %0d ticks", hs_ticks, runs, vs_ticks);
    endtask

    // One-clock reset while the counters sit inside the window.
    task automatic test_mid_reset();
        int c;
        bit found;
        int first_at;
        found = 1'b0;
        for (c = 0; c < 4 * FRAME + 8; c++) begin
            @(negedge clock_50);
            if (bench_ph == 1'b1 && px_h(tick_j) == 20 && px_v(tick_j) == 10) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL mid_reset_target got none want (20,10)"); end
        reset = 1'b0;
        @(negedge clock_50);
        reset = 1'b1;
        n_tests++; if (adr !== '0) begin n_fail++; $display("FAIL mid_reset_adr got %h want 0", adr); end
        n_tests++; if (vga_clk !== 1'b0) begin n_fail++; $display("FAIL mid_reset_vga_clk got %b want 0", vga_clk); end
        n_tests++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin n_fail++; $display("FAIL mid_reset_rgb got %h want 0", {vga_r, vga_g, vga_b}); end
        n_tests++; if (vga_blank_n !== 1'b0) begin n_fail++; $display("FAIL mid_reset_blank_n got %b want 0", vga_blank_n); end
        n_tests++; if (vga_hs !== ~HS_POL || vga_vs !== ~VS_POL) begin n_fail++; $display("FAIL mid_reset_sync got %b%b want %b%b", vga_hs, vga_vs, ~HS_POL, ~VS_POL); end
        first_at = -1;
        for (c = 1; c <= 20; c++) begin
            @(negedge clock_50);
            if (frame_start === 1'b1) begin
                first_at = c;
                break;
            end
        end
        n_tests++; if (first_at != 2) begin n_fail++; $display("FAIL mid_reset_frame_start got clock %0d want 2", first_at); end
        $display("[TB] mid-frame reset at (20,10), frame_start after %0d clocks", first_at);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) fb[i] = PIX_W'($urandom);
        test_reset();
        test_frame_start();
        test_scan(2, 24'h00FF00);
        test_sync_widths();
        test_mid_reset();
        test_scan(1, PIX_W'($urandom));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired after 5 ms");
        $fatal(1, "timeout");
    end

endmodule
